sram22_param_model: RTL and testbench

Parametrised behavioural model of a single-port SRAM22 macro, generalising the fixed-size 256x32 model to arbitrary width, depth, write-mask granularity and read latency. Adds chip enable, an explicit `dout_valid` strobe, and a hardware clear engine that zeroes the array after reset, with `busy` asserted while it runs. It sits in the same slot as the per-macro simulation models: instantiated by SoC testbenches and by the macro-level regression in place of the extracted netlist.

---
 rtl/sram22_param_model.sv | 190 +++++++++++++++++++
 tb/tb_sram22_param_model.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram22_param_model.sv
// sram22_param_model
//   Parametrised behavioural model of a single-port SRAM22 macro with
//   lane write mask, chip enable, 1- or 2-cycle read latency, a dout_valid
//   strobe and a clear engine that zeroes the whole array after reset.
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   ce         in   chip enable
//   we         in   1 = write, 0 = read (qualified by ce)
//   wmask      in   lane enables, bit k covers din[k*LANE +: LANE]
//   addr       in   word address
//   din        in   write data
//   dout       out  registered read data
//   dout_valid out  one-cycle strobe when dout carries new read data
//   busy       out  clear engine running, all accesses ignored
//
// Build option
//   SRAM22_X_ON_WRITE_EN : when defined, dout goes all-X on every accepted
//   write (unless a pipelined read result lands on the same edge).
//   Undefined (default): dout holds its value across writes.
//
// States
//   ST_CLEAR | zeroing mem[cnt_q] each edge, busy high
//   ST_IDLE  | normal read/write operation
module sram22_param_model #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int WMASK_WIDTH  = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   we,
    input  logic [WMASK_WIDTH-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    output logic                   busy
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
    localparam int LANE      = DATA_WIDTH / WMASK_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  mem_q [RAM_DEPTH];

    logic                   clr_wr;
    logic                   rd_req;
    logic                   wr_req;
    logic [DATA_WIDTH-1:0]  rd_data;

    logic                   deliver_vld;
    logic [DATA_WIDTH-1:0]  deliver_data;

    logic [DATA_WIDTH-1:0]  dout_q;
    logic                   dout_valid_q;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if ((DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_bad_mask
        $fatal(1, "sram22_param_model: DATA_WIDTH must be a multiple of WMASK_WIDTH");
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b1;
        clr_wr  = 1'b0;
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_wr = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                // Leave on the same edge that clears the last word, so busy
                // is high for exactly RAM_DEPTH edges.
                if (cnt_q == '1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                busy   = 1'b0;
                rd_req = ce & ~we;
                wr_req = ce & we;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
        // Reset wins over anything presented in the same cycle.
        if (rst) begin
            clr_wr = 1'b0;
            rd_req = 1'b0;
            wr_req = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Array
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr_wr) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_req) begin
            for (int k = 0; k < WMASK_WIDTH; k++) begin
                if (wmask[k]) begin
                    mem_q[addr][k*LANE +: LANE] <= din[k*LANE +: LANE];
                end
            end
        end
    end

    // Pre-edge content: a read sees the array as it was before this edge.
    assign rd_data = mem_q[addr];

    // ------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------
    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s1_vld_q;
        logic [DATA_WIDTH-1:0] s1_data_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_vld_q  <= 1'b0;
                s1_data_q <= '0;
            end else begin
                s1_vld_q <= rd_req;
                if (rd_req) begin
                    s1_data_q <= rd_data;
                end
            end
        end

        assign deliver_vld  = s1_vld_q;
        assign deliver_data = s1_data_q;
    end else if (READ_LATENCY == 1) begin : g_lat1
        assign deliver_vld  = rd_req;
        assign deliver_data = rd_data;
    end else begin : g_bad_latency
        $fatal(1, "sram22_param_model: READ_LATENCY must be 1 or 2");
        assign deliver_vld  = 1'b0;
        assign deliver_data = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= deliver_vld;
            if (deliver_vld) begin
                dout_q <= deliver_data;
            end
`ifdef SRAM22_X_ON_WRITE_EN
            // A result already in flight still lands intact.
            else if (wr_req) begin
                dout_q <= 'x;
            end
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_sram22_param_model.sv
module tb_sram22_param_model;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        we;
    logic [3:0]  wmask;
    logic [7:0]  addr;
    logic [31:0] din;

    logic [31:0] dout1, dout2;
    logic        valid1, valid2;
    logic        busy1, busy2;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_mem [256];
    int          clr_left;
    int          edge_n;
    int          due1[$];
    int          due2[$];
    logic [31:0] dat1[$];
    logic [31:0] dat2[$];
    logic [31:0] last1, last2;
    logic        exp_v1, exp_v2;
    logic [31:0] exp_d1, exp_d2;
    logic        exp_busy;

    sram22_param_model #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .WMASK_WIDTH(4), .READ_LATENCY(1)
    ) dut1 (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .wmask(wmask), .addr(addr),
        .din(din), .dout(dout1), .dout_valid(valid1), .busy(busy1)
    );

    sram22_param_model #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .WMASK_WIDTH(4), .READ_LATENCY(2)
    ) dut2 (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .wmask(wmask), .addr(addr),
        .din(din), .dout(dout2), .dout_valid(valid2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus, advance the model by one edge, wait for
    // the edge and settle 1 time unit after it.
    task automatic do_cycle(input logic r, input logic c, input logic w,
                            input logic [3:0] m, input logic [7:0] a,
                            input logic [31:0] d);
        logic wr_acc;
        rst = r; ce = c; we = w; wmask = m; addr = a; din = d;
        edge_n++;
        wr_acc = 1'b0;
        if (r) begin
            clr_left = 256;
            due1.delete(); due2.delete(); dat1.delete(); dat2.delete();
            for (int i = 0; i < 256; i++) m_mem[i] = '0;
            last1 = '0; last2 = '0;
        end else if (clr_left > 0) begin
            clr_left--;
        end else if (c) begin
            if (w) begin
                wr_acc = 1'b1;
                for (int k = 0; k < 4; k++)
                    if (m[k]) m_mem[a][k*8 +: 8] = d[k*8 +: 8];
            end else begin
                due1.push_back(edge_n);     dat1.push_back(m_mem[a]);
                due2.push_back(edge_n + 1); dat2.push_back(m_mem[a]);
            end
        end
        exp_v1 = 1'b0;
        if (due1.size() > 0 && due1[0] == edge_n) begin
            exp_v1 = 1'b1; last1 = dat1[0];
            void'(due1.pop_front()); void'(dat1.pop_front());
        end
`ifdef SRAM22_X_ON_WRITE_EN
        else if (wr_acc) last1 = 'x;
`endif
        exp_v2 = 1'b0;
        if (due2.size() > 0 && due2[0] == edge_n) begin
            exp_v2 = 1'b1; last2 = dat2[0];
            void'(due2.pop_front()); void'(dat2.pop_front());
        end
`ifdef SRAM22_X_ON_WRITE_EN
        else if (wr_acc) last2 = 'x;
`endif
        exp_d1 = last1;
        exp_d2 = last2;
        exp_busy = (clr_left > 0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int n1, n2;
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
            checks++;
            if (busy1 !== 1'b1 || busy2 !== 1'b1 || dout1 !== 32'h0 || dout2 !== 32'h0
                || valid1 !== 1'b0 || valid2 !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: busy=%b/%b dout=%h/%h valid=%b/%b required busy=1 dout=0 valid=0",
                         busy1, busy2, dout1, dout2, valid1, valid2);
            end
        end
        n1 = busy1 ? 1 : 0;
        n2 = busy2 ? 1 : 0;
        for (int i = 0; i < 260; i++) begin
            do_cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
            if (busy1) n1++;
            if (busy2) n2++;
        end
        checks++;
        if (n1 != 256 || n2 != 256 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL clear_duration: busy cycles=%0d/%0d final busy=%b/%b required 256 then 0",
                     n1, n2, busy1, busy2);
        end
        do_cycle(1'b0, 1'b1, 1'b0, 4'h0, 8'h55, 32'h0);
        checks++;
        if (valid1 !== 1'b1 || dout1 !== 32'h0 || valid2 !== 1'b0) begin
            errors++;
            $display("FAIL read_after_clear_l1: valid=%b dout=%h (l2 valid=%b) required 1/0 (0)",
                     valid1, dout1, valid2);
        end
        do_cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        checks++;
        if (valid2 !== 1'b1 || dout2 !== 32'h0 || valid1 !== 1'b0) begin
            errors++;
            $display("FAIL read_after_clear_l2: valid=%b dout=%h (l1 valid=%b) required 1/0 (0)",
                     valid2, dout2, valid1);
        end
    endtask

    task automatic test_masked_write;
        do_cycle(1'b0, 1'b1, 1'b1, 4'b1111, 8'h10, 32'hDEADBEEF);
        do_cycle(1'b0, 1'b1, 1'b1, 4'b0101, 8'h10, 32'h11223344);
        do_cycle(1'b0, 1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
        checks++;
        if (valid1 !== 1'b1 || dout1 !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL masked_write_l1: valid=%b dout=%h required 1/DE22BE44", valid1, dout1);
        end
        do_cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        checks++;
        if (valid2 !== 1'b1 || dout2 !== 32'hDE22BE44) begin
            errors++;
            $display("FAIL masked_write_l2: valid=%b dout=%h required 1/DE22BE44", valid2, dout2);
        end
    endtask

    task automatic test_pipelined;
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            v = 32'hA0 + 32'(i);
            do_cycle(1'b0, 1'b1, 1'b1, 4'hF, 8'(i), v);
        end
        for (int i = 0; i < 6; i++) begin
            if (i < 4) do_cycle(1'b0, 1'b1, 1'b0, 4'h0, 8'(i), 32'h0);
            else       do_cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
            // L=1: valid after cycles 0..3; L=2: valid after cycles 1..4
            checks++;
            if ((i < 4) ? (valid1 !== 1'b1 || dout1 !== 32'hA0 + 32'(i)) : (valid1 !== 1'b0)) begin
                errors++;
                $display("FAIL pipelined_l1[%0d]: valid=%b dout=%h required valid=%0d dout=%h",
                         i, valid1, dout1, (i < 4), 32'hA0 + 32'(i));
            end
            checks++;
            if ((i >= 1 && i <= 4) ? (valid2 !== 1'b1 || dout2 !== 32'hA0 + 32'(i - 1))
                                   : (valid2 !== 1'b0)) begin
                errors++;
                $display("FAIL pipelined_l2[%0d]: valid=%b dout=%h required valid=%0d dout=%h",
                         i, valid2, dout2, (i >= 1 && i <= 4), 32'hA0 + 32'(i - 1));
            end
        end
    endtask

    task automatic test_busy_access;
        int bad;
        do_cycle(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == 10)      do_cycle(1'b0, 1'b1, 1'b1, 4'hF, 8'h20, 32'hFFFFFFFF);
            else if (i == 40) do_cycle(1'b0, 1'b1, 1'b1, 4'hF, 8'h05, 32'hAAAA5555);
            else if (i == 60) do_cycle(1'b0, 1'b1, 1'b0, 4'h0, 8'h05, 32'h0);
            else              do_cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
            if (valid1 !== 1'b0 || valid2 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL busy_access: valid strobes during clear=%0d final busy=%b/%b required 0 and 0",
                     bad, busy1, busy2);
        end
        do_cycle(1'b0, 1'b1, 1'b0, 4'h0, 8'h20, 32'h0);
        do_cycle(1'b0, 1'b1, 1'b0, 4'h0, 8'h05, 32'h0);
        checks++;
        if (valid2 !== 1'b1 || dout2 !== 32'h0) begin
            errors++;
            $display("FAIL busy_write_0x20: valid=%b dout=%h required 1/00000000", valid2, dout2);
        end
        checks++;
        if (valid1 !== 1'b1 || dout1 !== 32'h0) begin
            errors++;
            $display("FAIL busy_write_0x05: valid=%b dout=%h required 1/00000000", valid1, dout1);
        end
        do_cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    endtask

    task automatic test_reset_mid;
        int n2, bad2;
        do_cycle(1'b0, 1'b1, 1'b1, 4'hF, 8'h30, 32'h12345678);
        do_cycle(1'b0, 1'b1, 1'b0, 4'h0, 8'h30, 32'h0);
        checks++;
        if (valid1 !== exp_v1 || dout1 !== exp_d1) begin
            errors++;
            $display("FAIL reset_mid_l1_read: valid=%b dout=%h required %b/%h", valid1, dout1, exp_v1, exp_d1);
        end
        do_cycle(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        bad2 = valid2 ? 1 : 0;
        n2 = busy2 ? 1 : 0;
        for (int i = 0; i < 260; i++) begin
            do_cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
            if (busy2) n2++;
            if (valid2) bad2++;
        end
        checks++;
        if (bad2 != 0 || n2 != 256) begin
            errors++;
            $display("FAIL reset_mid: dropped-read strobes=%0d busy cycles=%0d required 0 and 256", bad2, n2);
        end
        do_cycle(1'b0, 1'b1, 1'b0, 4'h0, 8'h30, 32'h0);
        do_cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        checks++;
        if (valid2 !== 1'b1 || dout2 !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_0x30: valid=%b dout=%h required 1/00000000", valid2, dout2);
        end
    endtask

    task automatic test_write_x;
        logic [31:0] want;
`ifdef SRAM22_X_ON_WRITE_EN
        want = 'x;
`else
        want = 32'h0;
`endif
        do_cycle(1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 32'h0);
        do_cycle(1'b0, 1'b1, 1'b1, 4'hF, 8'h01, 32'h00000077);
        checks++;
        if (valid1 !== 1'b0 || dout1 !== want) begin
            errors++;
            $display("FAIL write_dout_l1: valid=%b dout=%h required 0/%h", valid1, dout1, want);
        end
        checks++;
        if (valid2 !== 1'b1 || dout2 !== 32'h0) begin
            errors++;
            $display("FAIL write_inflight_l2: valid=%b dout=%h required 1/00000000", valid2, dout2);
        end
        do_cycle(1'b0, 1'b1, 1'b0, 4'h0, 8'h01, 32'h0);
        checks++;
        if (valid1 !== 1'b1 || dout1 !== 32'h77) begin
            errors++;
            $display("FAIL read_after_write: valid=%b dout=%h required 1/00000077", valid1, dout1);
        end
        do_cycle(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    endtask

    task automatic test_random;
        logic c, w;
        for (int i = 0; i < 600; i++) begin
            c = ($urandom_range(0, 3) != 0);
            w = $urandom_range(0, 1) != 0;
            do_cycle(1'b0, c, w, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), $urandom);
            checks++;
            if (valid1 !== exp_v1 || dout1 !== exp_d1 || busy1 !== exp_busy) begin
                errors++;
                $display("FAIL random_l1[%0d]: valid=%b dout=%h busy=%b required %b/%h/%b",
                         i, valid1, dout1, busy1, exp_v1, exp_d1, exp_busy);
            end
            checks++;
            if (valid2 !== exp_v2 || dout2 !== exp_d2 || busy2 !== exp_busy) begin
                errors++;
                $display("FAIL random_l2[%0d]: valid=%b dout=%h busy=%b required %b/%h/%b",
                         i, valid2, dout2, busy2, exp_v2, exp_d2, exp_busy);
            end
        end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; we = 1'b0; wmask = '0; addr = '0; din = '0;
        clr_left = 256; edge_n = 0; last1 = '0; last2 = '0;
        exp_v1 = 1'b0; exp_v2 = 1'b0; exp_d1 = '0; exp_d2 = '0; exp_busy = 1'b1;
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        test_reset();
        test_masked_write();
        test_pipelined();
        test_busy_access();
        test_reset_mid();
        test_write_x();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
